// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: next-PC selector codes,
// fetch FSM states and the default reset vector.
package mips_pkg;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [31:0] MIPS_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/npc.sv
// Next-PC candidate generator: selects sequential/branch/jump/jr target
// and flags whether it is a legal fetch address for the instruction memory.
module npc
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = MIPS_RESET_PC,
  parameter int          IM_ADDR_W = 10
) (
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_npc_op,
  input  logic        i_branch_taken,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_target26,
  input  logic [31:0] i_rs_data,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_cand,
  output logic        o_legal
);

  // Bounds held in 33 bits so the upper limit cannot wrap near the top of memory.
  localparam logic [32:0] LO_BOUND = {1'b0, RESET_PC};
  localparam logic [32:0] HI_BOUND = LO_BOUND + (33'd4 << IM_ADDR_W);

  logic [31:0] w_seq;
  logic [31:0] w_br_off;
  logic [31:0] w_br;
  logic [31:0] w_jmp;
  logic [32:0] w_cand_ext;

  assign w_seq      = i_pc + 32'd4;
  assign w_br_off   = {{14{i_imm16[15]}}, i_imm16, 2'b00};
  assign w_br       = w_seq + w_br_off;
  assign w_jmp      = {w_seq[31:28], i_target26, 2'b00};
  assign o_pc_plus4 = w_seq;

  always_comb begin
    o_cand = w_seq;
    case (i_npc_op)
      NPC_SEQ: o_cand = w_seq;
      NPC_BR:  o_cand = i_branch_taken ? w_br : w_seq;
      NPC_J:   o_cand = w_jmp;
      NPC_JR:  o_cand = i_rs_data;
      default: o_cand = w_seq;
    endcase
  end

  assign w_cand_ext = {1'b0, o_cand};
  assign o_legal    = (o_cand[1:0] == 2'b00) &&
                      (w_cand_ext >= LO_BOUND) &&
                      (w_cand_ext < HI_BOUND);

endmodule

// File: rtl/pc_fetch.sv
// Program counter register with a RUN/HALTED fetch FSM; freezes on a halt
// request or an illegal next-PC and only reset brings it back to RUN.
module pc_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = MIPS_RESET_PC,
  parameter int          IM_ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [1:0]           npc_op,
  input  logic                 branch_taken,
  input  logic [15:0]          imm16,
  input  logic [25:0]          target26,
  input  logic [31:0]          rs_data,
  input  logic                 halt,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic [IM_ADDR_W-1:0] im_addr,
  output logic                 halted,
  output logic                 addr_err
);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        r_addr_err;
  logic        w_addr_err_next;
  logic [31:0] w_cand;
  logic        w_legal;

  npc #(
    .RESET_PC  (RESET_PC),
    .IM_ADDR_W (IM_ADDR_W)
  ) u_npc (
    .i_pc           (r_pc),
    .i_npc_op       (npc_op),
    .i_branch_taken (branch_taken),
    .i_imm16        (imm16),
    .i_target26     (target26),
    .i_rs_data      (rs_data),
    .o_pc_plus4     (pc_plus4),
    .o_cand         (w_cand),
    .o_legal        (w_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_addr_err <= w_addr_err_next;
    end
  end

  // Stall outranks halt, halt outranks an illegal redirect.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_addr_err_next = r_addr_err;
    if (r_state == ST_RUN && !stall) begin
      if (halt) begin
        w_state_next = ST_HALTED;
      end else if (!w_legal) begin
        w_state_next    = ST_HALTED;
        w_addr_err_next = 1'b1;
      end else begin
        w_pc_next = w_cand;
      end
    end
  end

  assign pc       = r_pc;
  assign im_addr  = r_pc[IM_ADDR_W+1:2];
  assign halted   = (r_state == ST_HALTED);
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized scoreboard bench for pc_fetch: a stimulus process feeds a
// behavioural model and queues expectations; a monitor compares after each edge.
module tb_pc_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          AW     = 10;

  typedef struct {
    logic [31:0]   pc;
    logic [31:0]   pc_plus4;
    logic [AW-1:0] im_addr;
    logic          halted;
    logic          addr_err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall = 1'b0;
  logic [1:0]    npc_op = 2'b00;
  logic          branch_taken = 1'b0;
  logic [15:0]   imm16 = 16'h0;
  logic [25:0]   target26 = 26'h0;
  logic [31:0]   rs_data = 32'h0;
  logic          halt = 1'b0;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic [AW-1:0] im_addr;
  logic          halted;
  logic          addr_err;

  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];

  logic [31:0] m_pc = RST_PC;
  logic        m_halted = 1'b0;
  logic        m_err = 1'b0;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(RST_PC), .IM_ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .npc_op       (npc_op),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .target26     (target26),
    .rs_data      (rs_data),
    .halt         (halt),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .im_addr      (im_addr),
    .halted       (halted),
    .addr_err     (addr_err)
  );

  // Reference: candidate from the architectural rules, plain 32-bit / 64-bit arithmetic.
  task automatic model(input logic r, input logic s, input logic [1:0] op, input logic bt,
                       input logic [15:0] imm, input logic [25:0] tgt, input logic [31:0] rs,
                       input logic h);
    logic [31:0] cand;
    longint      off;
    logic        ok;
    if (r) begin
      m_pc = RST_PC; m_halted = 1'b0; m_err = 1'b0;
    end else if (!m_halted && !s) begin
      if (h) begin
        m_halted = 1'b1;
      end else begin
        case (op)
          2'd0: cand = m_pc + 32'd4;
          2'd1: begin
            off  = 4 * longint'($signed(imm));
            cand = bt ? 32'(longint'(m_pc) + 4 + off) : m_pc + 32'd4;
          end
          2'd2: cand = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(tgt) * 32'd4);
          default: cand = rs;
        endcase
        ok = (cand % 4 == 0) && (longint'(cand) >= longint'(RST_PC)) &&
             (longint'(cand) < longint'(RST_PC) + 4 * (longint'(1) << AW));
        if (ok) m_pc = cand;
        else begin m_halted = 1'b1; m_err = 1'b1; end
      end
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [1:0] op, input logic bt,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic [31:0] rs,
                      input logic h);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; npc_op = op; branch_taken = bt;
    imm16 = imm; target26 = tgt; rs_data = rs; halt = h;
    model(r, s, op, bt, imm, tgt, rs, h);
    e.pc       = m_pc;
    e.pc_plus4 = m_pc + 32'd4;
    e.im_addr  = AW'((m_pc / 4) % (1 << AW));
    e.halted   = m_halted;
    e.addr_err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic seq_step();
    step(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
  endtask

  task automatic rst_step();
    step(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (pc !== e.pc || pc_plus4 !== e.pc_plus4 || im_addr !== e.im_addr ||
            halted !== e.halted || addr_err !== e.addr_err) begin
          miscompares++;
          $display("FAIL state t=%0t: pc=%h/%h pc_plus4=%h/%h im_addr=%h/%h halted=%b/%b addr_err=%b/%b (got/expected)",
                   $time, pc, e.pc, pc_plus4, e.pc_plus4, im_addr, e.im_addr,
                   halted, e.halted, addr_err, e.addr_err);
        end
      end
    end
  end

  initial begin : stimulus
    logic [1:0]  op;
    logic [25:0] tgt;
    logic [31:0] rs;
    logic [15:0] imm;
    rst_step();
    seq_step(); seq_step(); seq_step();
    seq_step();
    step(1'b0, 1'b0, 2'd1, 1'b1, 16'hFFFC, 26'h0, 32'h0, 1'b0);
    seq_step(); seq_step(); seq_step();
    step(1'b0, 1'b0, 2'd1, 1'b0, 16'hFFFC, 26'h0, 32'h0, 1'b0);
    rst_step();
    step(1'b0, 1'b0, 2'd2, 1'b0, 16'h0, 26'h0000C10, 32'h0, 1'b0);
    step(1'b0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3100, 1'b0);
    step(1'b0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3102, 1'b0);
    rst_step();
    step(1'b0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_0000, 1'b0);
    rst_step();
    step(1'b0, 1'b1, 2'd2, 1'b0, 16'h0, 26'h0000C10, 32'h0, 1'b1);
    step(1'b0, 1'b0, 2'd2, 1'b0, 16'h0, 26'h0000C10, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'($urandom), 2'($urandom), 1'($urandom), 16'($urandom),
           26'($urandom), $urandom, 1'($urandom));
    rst_step();
    // Biased random run: mostly in-range targets, occasional stalls, halts and resets.
    for (int i = 0; i < 3000; i++) begin
      op  = 2'($urandom_range(0, 3));
      imm = 16'($signed($urandom_range(0, 15)) - 8);
      tgt = ($urandom_range(0, 7) == 0) ? 26'($urandom) : 26'(32'hC00 + $urandom_range(0, 1023));
      rs  = ($urandom_range(0, 7) == 0) ? $urandom : RST_PC + 4 * $urandom_range(0, 1023);
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
        rst_step();
      else
        step(1'b0, ($urandom_range(0, 7) == 0), op, 1'($urandom), imm, tgt, rs,
             ($urandom_range(0, 31) == 0));
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and next-PC stage of the single-cycle MIPS datapath. It sits directly upstream of the instruction register: it holds the architectural PC, drives the instruction-memory word address, and picks the next PC from sequential, branch, jump and jump-register sources. A small RUN/HALTED state machine freezes fetch on a halt request or an illegal fetch address.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset. Must be word-aligned.
- `IM_ADDR_W`, default 10: instruction-memory word-address width. The memory holds 2^IM_ADDR_W words.

Ports:
- `clk`  in  1  system clock. Rising edge only.
- `rst`  in  1  reset. Synchronous and active-high.
- `stall`  in  1  hold PC this cycle.
- `npc_op`  in  2  next-PC select: 00 PC+4, 01 branch, 10 jump (j/jal), 11 jr.
- `branch_taken`  in  1  branch condition from the ALU. Only used when `npc_op`=01.
- `imm16`  in  16  branch offset, in words, signed.
- `target26`  in  26  jump target field.
- `rs_data`  in  32  register value used for jr.
- `halt`  in  1  halt request decoded from the current instruction.
- `pc`  out  32  current PC (registered).
- `pc_plus4`  out  32  `pc`+4, combinational. Also used for the jal link value.
- `im_addr`  out  IM_ADDR_W  equals `pc[IM_ADDR_W+1:2]`, combinational.
- `halted`  out  1  high in the HALTED state.
- `addr_err`  out  1  sticky flag for an illegal next-PC.

## Operation

- **Reset values:** `pc`=RESET_PC, `halted`=0, `addr_err`=0, state=RUN.
- **Candidate next-PC**, all arithmetic modulo 2^32:
  - sequential: `pc`+4
  - branch: `pc`+4 + (sign-extended `imm16` << 2). Used only if `branch_taken`=1; otherwise sequential.
  - jump: {`pc_plus4[31:28]`, `target26`, 2'b00}
  - jr: `rs_data`
- **Legality check:** the candidate is illegal if either condition holds:
  - bits [1:0] are not 0, or
  - it lies outside [RESET_PC, RESET_PC + 4·2^IM_ADDR_W).
- **RUN state, evaluated in priority order:**
  1. `stall`=1: PC holds. `halt` and legality are ignored this cycle.
  2. `halt`=1: PC holds at the halt instruction address; go to HALTED. `halt` wins over any redirect in the same cycle.
  3. Candidate illegal: PC holds; `addr_err`←1; go to HALTED.
  4. Otherwise: PC ← candidate.
- **HALTED state:** PC, `halted`=1 and `addr_err` are frozen. All inputs are ignored. Only `rst` leaves HALTED.
- **Wrap-around:** `pc`+4 from 32'hFFFF_FFFC gives 0. This is out of range, so it raises `addr_err`; there is no silent wrap.

## Timing

- PC register updates on the rising `clk` edge. No other state is held except the state bit and `addr_err`.
- `im_addr`, `pc_plus4` and all next-PC candidates are combinational from the current `pc` and inputs, with zero latency.
- Fetch timing:
  - The instruction at `pc` is presented by instruction memory in the same cycle.
  - The downstream instruction register captures it at the next edge, so `instr` lags `pc` by one cycle.
- Reset:
  - Sampled only at the rising edge. It overrides stall, halt and HALTED.
  - Asserting reset mid-run takes effect at that edge. The next cycle shows `pc`=RESET_PC, `halted`=0, `addr_err`=0.
- `halted` and `addr_err` rise at the same edge that commits the HALTED transition.

## Structure

- Shared package `mips_pkg` holds:
  - `NPC_SEQ`, `NPC_BR`, `NPC_J`, `NPC_JR` localparams (2-bit)
  - state encodings `ST_RUN` and `ST_HALTED`
  - default reset vector `MIPS_RESET_PC` = 32'h0000_3000
- One combinational sub-module, `npc`, computes the candidate and its legal flag from `pc`, `npc_op`, `branch_taken`, `imm16`, `target26`, `rs_data`.
- `pc_fetch` owns the registers and the FSM.

## Test plan

- Reset, then 3 cycles with `npc_op`=00: `pc` = 3000, 3004, 3008, 300C; `im_addr` = 0, 1, 2, 3.
- At `pc`=3010:
  - `npc_op`=01, `branch_taken`=1, `imm16`=16'hFFFC → next `pc`=3004.
  - Same with `branch_taken`=0 → next `pc`=3014.
- At `pc`=3000: `npc_op`=10, `target26`=26'h0000C10 → `pc`=3040.
- jr checks:
  - `rs_data`=32'h0000_3100 → `pc`=3100.
  - `rs_data`=32'h0000_3102 → `pc` holds, `addr_err`=1, `halted`=1.
  - `rs_data`=32'h0000_0000 → out of range, same response.
- Same cycle `stall`=1, `halt`=1, jump requested → PC holds and stays in RUN. Next cycle `stall`=0, `halt`=1, jump requested → `pc` unchanged, `halted`=1.
- While HALTED: drive random inputs for 5 cycles → `pc` frozen. Assert `rst` → next cycle `pc`=3000, `halted`=0, `addr_err`=0.
